// File: rtl/fe_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fe_fetch_unit_if
// Purpose : fetch-queue head handshake between the fetch unit and its consumer.
// Signals :
//   fetch_v_o          - queue head valid (driven by the fetch unit)
//   fetch_ready_i      - consumer accepts the head (driven by the consumer)
//   fetch_pc_o         - PC of the head entry
//   fetch_instr_o      - instruction word of the head entry
//   fetch_pred_pc_o    - predicted next PC recorded with the head entry
//   fetch_pred_taken_o - head entry was predicted taken
//   count_o            - number of entries currently queued
// Modports: master = fetch unit side, slave = consumer side.
// ----------------------------------------------------------------------------
interface fe_fetch_unit_if #(
    parameter int WORD_SIZE_P   = 16,
    parameter int QUEUE_DEPTH_P = 4
);
    logic                           fetch_v_o;
    logic                           fetch_ready_i;
    logic [WORD_SIZE_P-1:0]         fetch_pc_o;
    logic [WORD_SIZE_P-1:0]         fetch_instr_o;
    logic [WORD_SIZE_P-1:0]         fetch_pred_pc_o;
    logic                           fetch_pred_taken_o;
    logic [$clog2(QUEUE_DEPTH_P):0] count_o;

    modport master (
        output fetch_v_o, fetch_pc_o, fetch_instr_o, fetch_pred_pc_o,
               fetch_pred_taken_o, count_o,
        input  fetch_ready_i
    );

    modport slave (
        input  fetch_v_o, fetch_pc_o, fetch_instr_o, fetch_pred_pc_o,
               fetch_pred_taken_o, count_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/fe_fetch_unit.sv
// ----------------------------------------------------------------------------
// fe_fetch_unit
// Purpose : instruction fetch front end. Fetches one instruction per cycle
//           from a same-cycle ROM, predicts the next PC with a direct-mapped
//           BTB (2-bit counters), and buffers fetched entries in a small FIFO.
// Ports   :
//   clk_i, reset_i        - clock and asynchronous active-high reset
//   i_rom_r_addr_o        - fetch address (the PC register)
//   i_rom_data_i          - instruction at i_rom_r_addr_o, same cycle
//   redirect_v_i/_pc_i    - backend redirect: flush queue, restart at new PC
//   btb_update_*          - resolved-branch training port
//   fetch_if (master)     - queue head handshake and occupancy
// ----------------------------------------------------------------------------
module fe_fetch_unit #(
    parameter int                     WORD_SIZE_P   = 16,
    parameter int                     QUEUE_DEPTH_P = 4,
    parameter int                     BTB_ENTRIES_P = 8,
    parameter logic [WORD_SIZE_P-1:0] RESET_PC_P    = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic [WORD_SIZE_P-1:0] i_rom_r_addr_o,
    input  logic [WORD_SIZE_P-1:0] i_rom_data_i,
    input  logic                   redirect_v_i,
    input  logic [WORD_SIZE_P-1:0] redirect_pc_i,
    input  logic                   btb_update_v_i,
    input  logic [WORD_SIZE_P-1:0] btb_update_pc_i,
    input  logic [WORD_SIZE_P-1:0] btb_update_target_i,
    input  logic                   btb_update_taken_i,
    fe_fetch_unit_if.master        fetch_if
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH_P);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(BTB_ENTRIES_P);
    localparam int TAG_W = WORD_SIZE_P - IDX_W;

    typedef struct packed {
        logic [WORD_SIZE_P-1:0] pc;
        logic [WORD_SIZE_P-1:0] instr;
        logic [WORD_SIZE_P-1:0] pred_pc;
        logic                   pred_taken;
    } entry_t;

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       tag;
        logic [WORD_SIZE_P-1:0] target;
        logic [1:0]             ctr;
    } btb_entry_t;

    logic [WORD_SIZE_P-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    entry_t                 queue_q [QUEUE_DEPTH_P];
    entry_t                 queue_d [QUEUE_DEPTH_P];
    btb_entry_t             btb_q   [BTB_ENTRIES_P];
    btb_entry_t             btb_d   [BTB_ENTRIES_P];

    logic [IDX_W-1:0]       lookup_idx, upd_idx;
    logic [TAG_W-1:0]       lookup_tag, upd_tag;
    logic                   lookup_hit, upd_hit;
    logic                   pred_taken;
    logic [WORD_SIZE_P-1:0] pred_pc;
    logic                   enq, deq, fetch_v;

    // Lookup reads btb_q, so an update in the same cycle is not visible yet.
    always_comb begin
        lookup_idx = pc_q[IDX_W-1:0];
        lookup_tag = pc_q[WORD_SIZE_P-1:IDX_W];
        lookup_hit = btb_q[lookup_idx].valid && (btb_q[lookup_idx].tag == lookup_tag);
        pred_taken = lookup_hit && btb_q[lookup_idx].ctr[1];
        pred_pc    = pred_taken ? btb_q[lookup_idx].target : pc_q + WORD_SIZE_P'(1);
        // Full blocks enqueue even when a dequeue frees a slot this cycle.
        enq        = (count_q != CNT_W'(QUEUE_DEPTH_P)) && !redirect_v_i;
        fetch_v    = (count_q != '0) && !redirect_v_i;
        deq        = fetch_v && fetch_if.fetch_ready_i;
        upd_idx    = btb_update_pc_i[IDX_W-1:0];
        upd_tag    = btb_update_pc_i[WORD_SIZE_P-1:IDX_W];
        upd_hit    = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        queue_d  = queue_q;
        btb_d    = btb_q;

        if (redirect_v_i) begin
            // Flush drops any same-cycle enqueue/dequeue as well.
            pc_d     = redirect_pc_i;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq) begin
                queue_d[wr_ptr_q] = '{pc: pc_q, instr: i_rom_data_i,
                                      pred_pc: pred_pc, pred_taken: pred_taken};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pred_pc;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end

        // Training is independent of redirect and queue state.
        if (btb_update_v_i) begin
            if (upd_hit) begin
                if (btb_update_taken_i) begin
                    btb_d[upd_idx].target = btb_update_target_i;
                    if (btb_q[upd_idx].ctr != 2'd3) begin
                        btb_d[upd_idx].ctr = btb_q[upd_idx].ctr + 2'd1;
                    end
                end else if (btb_q[upd_idx].ctr != 2'd0) begin
                    btb_d[upd_idx].ctr = btb_q[upd_idx].ctr - 2'd1;
                end
            end else if (btb_update_taken_i) begin
                btb_d[upd_idx] = '{valid: 1'b1, tag: upd_tag,
                                   target: btb_update_target_i, ctr: 2'd2};
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q     <= RESET_PC_P;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH_P; i++) begin
                queue_q[i] <= '0;
            end
            for (int i = 0; i < BTB_ENTRIES_P; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'd1};
            end
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            queue_q  <= queue_d;
            btb_q    <= btb_d;
        end
    end

    assign i_rom_r_addr_o              = pc_q;
    assign fetch_if.fetch_v_o          = fetch_v;
    assign fetch_if.count_o            = count_q;
    assign fetch_if.fetch_pc_o         = queue_q[rd_ptr_q].pc;
    assign fetch_if.fetch_instr_o      = queue_q[rd_ptr_q].instr;
    assign fetch_if.fetch_pred_pc_o    = queue_q[rd_ptr_q].pred_pc;
    assign fetch_if.fetch_pred_taken_o = queue_q[rd_ptr_q].pred_taken;
endmodule

// File: doc/fe_fetch_unit.md
FE_FETCH_UNIT -- requirements
Module: fe_fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE_P, default 16, meaning PC and instruction width in bits.
REQ-002 SHALL have parameter QUEUE_DEPTH_P, default 4, meaning fetch queue entries; power of 2, at least 2.
REQ-003 SHALL have parameter BTB_ENTRIES_P, default 8, meaning branch target buffer entries; power of 2, at least 2.
REQ-004 SHALL have parameter RESET_PC_P, default 0, meaning PC value loaded on reset.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_rom_r_addr_o, output, WORD_SIZE_P bits: fetch address, equal to the PC register.
REQ-008 SHALL have port i_rom_data_i, input, WORD_SIZE_P bits: instruction at i_rom_r_addr_o, valid in the same cycle.
REQ-009 SHALL have port redirect_v_i, input, 1 bit: backend mispredict or redirect.
REQ-010 SHALL have port redirect_pc_i, input, WORD_SIZE_P bits: new fetch PC.
REQ-011 SHALL have ports btb_update_v_i, btb_update_pc_i, btb_update_target_i and btb_update_taken_i, inputs of 1, WORD_SIZE_P, WORD_SIZE_P and 1 bits: resolved-branch training.
REQ-012 SHALL have port fetch_v_o, output, 1 bit: queue head valid.
REQ-013 SHALL have port fetch_ready_i, input, 1 bit: consumer accepts the head.
REQ-014 SHALL have ports fetch_pc_o, fetch_instr_o and fetch_pred_pc_o, outputs, WORD_SIZE_P bits each: head entry fields.
REQ-015 SHALL have port fetch_pred_taken_o, output, 1 bit: head entry predicted taken.
REQ-016 SHALL have port count_o, output, $clog2(QUEUE_DEPTH_P)+1 bits: queue occupancy.

Function
REQ-017 SHALL form the BTB index as PC[$clog2(BTB_ENTRIES_P)-1:0] and the tag as the remaining upper PC bits.
REQ-018 SHALL, per BTB entry, hold a valid bit, tag, target and a 2-bit saturating counter.
REQ-019 SHALL declare a lookup hit only when the indexed entry is valid and its tag matches the current PC.
REQ-020 SHALL predict taken only when the lookup hits and counter bit 1 is set.
REQ-021 SHALL set pred_pc to the BTB target when predicted taken, else to PC+1 modulo 2^WORD_SIZE_P (0xFFFF wraps to 0x0000).
REQ-022 SHALL enqueue {PC, i_rom_data_i, pred_pc, pred_taken} at the edge when count_o < QUEUE_DEPTH_P and redirect_v_i=0; a full queue blocks the enqueue even if a dequeue occurs in the same cycle.
REQ-023 SHALL select the next PC with priority: redirect_v_i gives redirect_pc_i; otherwise an enqueue gives pred_pc; otherwise the PC holds.
REQ-024 SHALL drive fetch_v_o = (count_o != 0) & ~redirect_v_i.
REQ-025 SHALL dequeue when fetch_v_o & fetch_ready_i; fetch_* outputs hold stable while fetch_v_o=1 and fetch_ready_i=0.
REQ-026 SHALL give a latency of one cycle from the edge on which an entry is enqueued to that entry appearing at the head of an empty queue; there is no combinational bypass.
REQ-027 SHALL allow enqueue and dequeue in the same cycle, leaving count unchanged.
REQ-028 SHALL use wrapping read and write pointers modulo QUEUE_DEPTH_P.
REQ-029 SHALL, on redirect_v_i, zero the count and both pointers at the edge, discarding all entries and any same-cycle enqueue or dequeue.
REQ-030 SHALL, on btb_update_v_i with a hit at btb_update_pc_i, increment the counter if taken and decrement it if not taken, saturating at 3 and 0; target is overwritten only when taken.
REQ-031 SHALL, on btb_update_v_i with a miss and taken=1, allocate the entry by overwriting it with valid=1, the tag, the target and counter=2; on a miss with taken=0 the entry is unchanged.
REQ-032 SHALL apply BTB updates regardless of redirect_v_i or queue state.
REQ-033 SHALL make a lookup in the same cycle as an update to the same index see the pre-update contents.
REQ-034 SHALL leave entry valid=1 when the counter reaches 0.

Reset
REQ-035 SHALL, while reset_i=1 and without a clock edge, set PC=RESET_PC_P, count_o=0, pointers=0, every BTB valid=0 and every counter=1, with fetch_v_o=0.
REQ-036 SHALL fully discard any in-flight state when reset is asserted mid-operation; the first enqueue after deassertion is at RESET_PC_P.

Verification
REQ-037 SHALL cover: reset, fetch_ready_i=1, empty BTB -> head PCs 0,1,2,3 on consecutive cycles, first fetch_v_o one cycle after the first enqueue edge.
REQ-038 SHALL cover: fetch_ready_i=0 from reset -> count_o reaches 4, i_rom_r_addr_o holds 4; then fetch_ready_i=1 -> heads 0,1,2,3,4 in order.
REQ-039 SHALL cover: update pc=0x0005, target=0x0020, taken=1, then fetch reaches 5 -> entry pred_taken=1, pred_pc=0x0020, next address 0x0020.
REQ-040 SHALL cover: two not-taken updates at pc=0x0005 -> counter 2->1->0, fetch at 5 predicts 0x0006; a fetch at 0x000D (same index, different tag) misses.
REQ-041 SHALL cover: redirect_pc_i=0x0100 with count_o=3 -> fetch_v_o=0 that cycle, count_o=0 next cycle, i_rom_r_addr_o=0x0100.
REQ-042 SHALL cover: reset_i pulsed between clock edges with count_o=2 -> count_o=0 and i_rom_r_addr_o=RESET_PC_P immediately, BTB predictions cleared.
